// File: rtl/draw_row_sched.sv
// Row scheduler for a cel: steps a 16.16 row origin and hands rows one at a time to a row drawer.
// Optional vertical clipping of off-screen rows is built when DRAW_SCHED_CLIP_EN is defined.
module draw_row_sched #(
    parameter int COORD_WIDTH = 32,
    parameter int ROWS_WIDTH  = 16,
    parameter int YMAX        = 240
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [COORD_WIDTH-1:0] xpos_in,
    input  logic [COORD_WIDTH-1:0] ypos_in,
    input  logic [COORD_WIDTH-1:0] vdx_in,
    input  logic [COORD_WIDTH-1:0] vdy_in,
    input  logic [ROWS_WIDTH-1:0]  nrows_in,
    input  logic [31:0]            cnt_in,
    output logic                   row_req,
    input  logic                   row_busy,
    output logic [COORD_WIDTH-1:0] xcur,
    output logic [COORD_WIDTH-1:0] ycur,
    output logic [31:0]            cnt,
    output logic [ROWS_WIDTH-1:0]  row_idx,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_REQ  = 3'd2,
        S_WAIT = 3'd3,
        S_STEP = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    state_t                 state_r, next_state_s;
    logic [COORD_WIDTH-1:0] xpos_r, ypos_r, vdx_r, vdy_r;
    logic [ROWS_WIDTH-1:0]  nrows_r;
    logic [31:0]            cnt_r;
    logic [COORD_WIDTH-1:0] xcur_r, ycur_r, xcur_nxt_s, ycur_nxt_s;
    logic [ROWS_WIDTH-1:0]  row_idx_r, row_idx_nxt_s;
    logic                   abort_lat_r, latch_abort_s, abort_pend_s;
    logic                   fin_abort_s, last_row_s;
    logic                   clip_cur_s, clip_nxt_s;
    logic                   row_req_r, busy_r, done_r, aborted_r;
    logic                   row_req_nxt_s, busy_nxt_s, done_nxt_s, aborted_nxt_s;

`ifdef DRAW_SCHED_CLIP_EN
    localparam int YINT_W = COORD_WIDTH - 16;
    localparam logic [YINT_W-1:0] YMAX_C = YINT_W'(YMAX);

    // Integer scanline is off-screen when negative or at/after the clip limit.
    function automatic logic y_clipped(input logic [YINT_W-1:0] yint);
        y_clipped = yint[YINT_W-1] || (yint >= YMAX_C);
    endfunction

    assign clip_cur_s = y_clipped(ycur_r[COORD_WIDTH-1:16]);
    assign clip_nxt_s = y_clipped(ycur_nxt_s[COORD_WIDTH-1:16]);
`else
    logic unused_ymax_s;
    assign unused_ymax_s = (YMAX != 0);
    assign clip_cur_s    = 1'b0;
    assign clip_nxt_s    = 1'b0;
`endif

    assign abort_pend_s = abort | abort_lat_r;
    assign last_row_s   = ((row_idx_r + {{(ROWS_WIDTH-1){1'b0}}, 1'b1}) == nrows_r);

    // State register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; also decides whether FIN is reached through an abort.
    always_comb begin
        next_state_s  = state_r;
        fin_abort_s   = 1'b0;
        latch_abort_s = abort_lat_r;
        case (state_r)
            S_IDLE: begin
                latch_abort_s = 1'b0;
                next_state_s  = start ? S_LOAD : S_IDLE;
            end
            S_LOAD: begin
                if (abort) begin
                    next_state_s = S_FIN;
                    fin_abort_s  = 1'b1;
                end else if ((nrows_r == {ROWS_WIDTH{1'b0}}) || (cnt_r == 32'd0)) begin
                    next_state_s = S_FIN;
                end else begin
                    next_state_s = S_REQ;
                end
            end
            S_REQ: begin
                // Once the drawer has accepted the row an abort must wait for it to finish.
                if (row_busy) begin
                    next_state_s  = S_WAIT;
                    latch_abort_s = abort_pend_s;
                end else if (abort_pend_s) begin
                    next_state_s = S_FIN;
                    fin_abort_s  = 1'b1;
                end else if (clip_cur_s) begin
                    next_state_s = S_STEP;
                end else begin
                    next_state_s = S_REQ;
                end
            end
            S_WAIT: begin
                if (row_busy) begin
                    next_state_s  = S_WAIT;
                    latch_abort_s = abort_pend_s;
                end else if (abort_pend_s) begin
                    next_state_s = S_FIN;
                    fin_abort_s  = 1'b1;
                end else begin
                    next_state_s = S_STEP;
                end
            end
            S_STEP: begin
                latch_abort_s = abort_pend_s;
                next_state_s  = last_row_s ? S_FIN : S_REQ;
            end
            S_FIN: begin
                latch_abort_s = 1'b0;
                next_state_s  = S_IDLE;
            end
            default: begin
                latch_abort_s = 1'b0;
                next_state_s  = S_IDLE;
            end
        endcase
    end

    // Row origin and index: loaded in LOAD, advanced in STEP, otherwise held.
    always_comb begin
        xcur_nxt_s    = xcur_r;
        ycur_nxt_s    = ycur_r;
        row_idx_nxt_s = row_idx_r;
        case (state_r)
            S_LOAD: begin
                xcur_nxt_s    = xpos_r;
                ycur_nxt_s    = ypos_r;
                row_idx_nxt_s = {ROWS_WIDTH{1'b0}};
            end
            S_STEP: begin
                xcur_nxt_s    = xcur_r + vdx_r;
                ycur_nxt_s    = ycur_r + vdy_r;
                row_idx_nxt_s = row_idx_r + {{(ROWS_WIDTH-1){1'b0}}, 1'b1};
            end
            default: begin
                xcur_nxt_s    = xcur_r;
                ycur_nxt_s    = ycur_r;
                row_idx_nxt_s = row_idx_r;
            end
        endcase
    end

    // Output decode from the upcoming state so every output is a flop.
    always_comb begin
        row_req_nxt_s = (next_state_s == S_REQ) && !clip_nxt_s;
        busy_nxt_s    = (next_state_s == S_LOAD) || (next_state_s == S_REQ) ||
                        (next_state_s == S_WAIT) || (next_state_s == S_STEP);
        done_nxt_s    = (next_state_s == S_FIN);
        aborted_nxt_s = fin_abort_s;
    end

    // Parameter latch, datapath and output registers.
    always_ff @(posedge aclk) begin
        if (areset) begin
            xpos_r      <= {COORD_WIDTH{1'b0}};
            ypos_r      <= {COORD_WIDTH{1'b0}};
            vdx_r       <= {COORD_WIDTH{1'b0}};
            vdy_r       <= {COORD_WIDTH{1'b0}};
            nrows_r     <= {ROWS_WIDTH{1'b0}};
            cnt_r       <= 32'd0;
            xcur_r      <= {COORD_WIDTH{1'b0}};
            ycur_r      <= {COORD_WIDTH{1'b0}};
            row_idx_r   <= {ROWS_WIDTH{1'b0}};
            abort_lat_r <= 1'b0;
            row_req_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            aborted_r   <= 1'b0;
        end else begin
            if ((state_r == S_IDLE) && start) begin
                xpos_r  <= xpos_in;
                ypos_r  <= ypos_in;
                vdx_r   <= vdx_in;
                vdy_r   <= vdy_in;
                nrows_r <= nrows_in;
                cnt_r   <= cnt_in;
            end
            xcur_r      <= xcur_nxt_s;
            ycur_r      <= ycur_nxt_s;
            row_idx_r   <= row_idx_nxt_s;
            abort_lat_r <= latch_abort_s;
            row_req_r   <= row_req_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
            aborted_r   <= aborted_nxt_s;
        end
    end

    assign row_req = row_req_r;
    assign xcur    = xcur_r;
    assign ycur    = ycur_r;
    assign cnt     = cnt_r;
    assign row_idx = row_idx_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign aborted = aborted_r;

endmodule

// File: tb/tb_draw_row_sched.sv
// Self-checking bench for draw_row_sched: a row-drawer model pops expected rows from a scoreboard.
module tb_draw_row_sched;

    logic        aclk = 1'b0;
    logic        areset, start, abort, row_busy;
    logic [31:0] xpos_in, ypos_in, vdx_in, vdy_in, cnt_in;
    logic [15:0] nrows_in;
    logic        row_req, busy, done, aborted;
    logic [31:0] xcur, ycur, cnt;
    logic [15:0] row_idx;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] c;
        logic [15:0] idx;
    } row_t;

    row_t sb_q[$];
    row_t cur_exp;
    int   checks = 0;
    int   passed = 0;
    int   busy_len = 3;
    int   busy_cnt = 0;
    int   req_count = 0;
    int   ncyc = 0;
    int   last_fall = -1;

    always #5 aclk = ~aclk;

    draw_row_sched dut (
        .aclk(aclk), .areset(areset), .start(start), .abort(abort),
        .xpos_in(xpos_in), .ypos_in(ypos_in), .vdx_in(vdx_in), .vdy_in(vdy_in),
        .nrows_in(nrows_in), .cnt_in(cnt_in), .row_req(row_req), .row_busy(row_busy),
        .xcur(xcur), .ycur(ycur), .cnt(cnt), .row_idx(row_idx),
        .busy(busy), .done(done), .aborted(aborted)
    );

    // Row drawer model: accepts each request, checks it against the scoreboard, stays busy busy_len cycles.
    initial begin
        row_busy = 1'b0;
        forever begin
            @(negedge aclk);
            ncyc++;
            if (areset) begin
                row_busy = 1'b0;
                busy_cnt = 0;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    checks++;
                    if ({xcur, ycur, cnt, row_idx} !== cur_exp)
                        $display("FAIL row_stable: got x=%h y=%h c=%h idx=%0d, want x=%h y=%h c=%h idx=%0d",
                                 xcur, ycur, cnt, row_idx, cur_exp.x, cur_exp.y, cur_exp.c, cur_exp.idx);
                    else passed++;
                    row_busy  = 1'b0;
                    last_fall = ncyc;
                end
            end else if (row_req) begin
                req_count++;
                checks++;
                if (sb_q.size() == 0) begin
                    $display("FAIL unexpected_row_req: got row_req=1 y=%h idx=%0d, want no request", ycur, row_idx);
                end else begin
                    cur_exp = sb_q.pop_front();
                    if ({xcur, ycur, cnt, row_idx} !== cur_exp)
                        $display("FAIL row: got x=%h y=%h c=%h idx=%0d, want x=%h y=%h c=%h idx=%0d",
                                 xcur, ycur, cnt, row_idx, cur_exp.x, cur_exp.y, cur_exp.c, cur_exp.idx);
                    else passed++;
                end
                if (last_fall >= 0) begin
                    checks++;
                    if (ncyc - last_fall !== 2)
                        $display("FAIL busy_to_req_latency: got %0d cycles, want 2", ncyc - last_fall);
                    else passed++;
                end
                last_fall = -1;
                row_busy  = 1'b1;
                busy_cnt  = busy_len;
            end
        end
    end

    task automatic push_rows(input logic [31:0] x, input logic [31:0] y, input logic [31:0] dx,
                             input logic [31:0] dy, input int n, input logic [31:0] c);
        row_t r;
        for (int i = 0; i < n; i++) begin
            r.x   = x + dx * i;
            r.y   = y + dy * i;
            r.c   = c;
            r.idx = 16'(i);
            sb_q.push_back(r);
        end
    endtask

    // Called at a negedge; returns at the negedge after the start edge (DUT in LOAD).
    task automatic do_start(input logic [31:0] x, input logic [31:0] y, input logic [31:0] dx,
                            input logic [31:0] dy, input logic [15:0] n, input logic [31:0] c,
                            input logic ab);
        xpos_in = x; ypos_in = y; vdx_in = dx; vdy_in = dy; nrows_in = n; cnt_in = c;
        start = 1'b1; abort = ab; last_fall = -1;
        @(negedge aclk);
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        for (int k = 0; k < 2000; k++) begin
            if (done) break;
            @(negedge aclk);
        end
        seen = done;
    endtask

    task automatic test_reset;
        areset = 1'b1;
        repeat (2) @(negedge aclk);
        checks++;
        if ({row_req, busy, done, aborted, xcur, ycur, cnt, row_idx} !== 116'd0)
            $display("FAIL reset_outputs: got req=%b busy=%b done=%b ab=%b x=%h y=%h c=%h idx=%0d, want all 0",
                     row_req, busy, done, aborted, xcur, ycur, cnt, row_idx);
        else passed++;
        areset = 1'b0;
        @(negedge aclk);
    endtask

    task automatic test_basic;
        bit seen;
        int r0 = req_count;
        busy_len = 20;
        push_rows(32'h10000, 32'h30000, 32'h0, 32'h10000, 3, 32'h10);
        do_start(32'h10000, 32'h30000, 32'h0, 32'h10000, 16'd3, 32'h10, 1'b0);
        checks++;
        if ({row_req, busy} !== 2'b01) $display("FAIL load_cycle: got req=%b busy=%b, want req=0 busy=1", row_req, busy);
        else passed++;
        // A second start while running must be ignored.
        xpos_in = 32'hDEAD0000; nrows_in = 16'd9; start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        checks++;
        if (row_req !== 1'b1) $display("FAIL start_latency: got row_req=%b, want 1", row_req);
        else passed++;
        wait_done(seen);
        checks++;
        if ({seen, aborted, busy} !== 3'b100) $display("FAIL basic_done: got done=%b ab=%b busy=%b, want 1 0 0", seen, aborted, busy);
        else passed++;
        checks++;
        if ((req_count - r0 !== 3) || (sb_q.size() !== 0))
            $display("FAIL basic_rows: got %0d requests, %0d left, want 3 and 0", req_count - r0, sb_q.size());
        else passed++;
        @(negedge aclk);
        checks++;
        if (done !== 1'b0) $display("FAIL done_pulse: got done=%b one cycle later, want 0", done);
        else passed++;
    endtask

    task automatic test_zero_rows;
        int r0 = req_count;
        for (int t = 0; t < 2; t++) begin
            if (t == 0) do_start(32'h0, 32'h0, 32'h0, 32'h0, 16'd0, 32'h5, 1'b0);
            else        do_start(32'h0, 32'h0, 32'h0, 32'h0, 16'd2, 32'h0, 1'b0);
            @(negedge aclk);
            checks++;
            if ({done, aborted} !== 2'b10) $display("FAIL zero_done_t%0d: got done=%b ab=%b, want 1 0", t, done, aborted);
            else passed++;
            @(negedge aclk);
        end
        checks++;
        if (req_count !== r0) $display("FAIL zero_no_req: got %0d requests, want 0", req_count - r0);
        else passed++;
    endtask

    task automatic test_abort_wait;
        bit seen;
        int r0 = req_count;
        busy_len = 6;
        push_rows(32'h0, 32'h0, 32'h8000, 32'h10000, 2, 32'h20);
        do_start(32'h0, 32'h0, 32'h8000, 32'h10000, 16'd4, 32'h20, 1'b0);
        for (int k = 0; k < 200; k++) begin
            if ((row_idx == 16'd1) && row_busy) break;
            @(negedge aclk);
        end
        abort = 1'b1;
        @(negedge aclk);
        abort = 1'b0;
        wait_done(seen);
        checks++;
        if ({seen, aborted} !== 2'b11) $display("FAIL abort_wait_done: got done=%b ab=%b, want 1 1", seen, aborted);
        else passed++;
        checks++;
        if ((req_count - r0 !== 2) || (sb_q.size() !== 0))
            $display("FAIL abort_wait_rows: got %0d requests, %0d left, want 2 and 0", req_count - r0, sb_q.size());
        else passed++;
        @(negedge aclk);
    endtask

    task automatic test_abort_load;
        int r0 = req_count;
        do_start(32'h0, 32'h0, 32'h0, 32'h0, 16'd2, 32'h4, 1'b0);
        abort = 1'b1;
        @(negedge aclk);
        abort = 1'b0;
        checks++;
        if ({done, aborted, row_req} !== 3'b110) $display("FAIL abort_load: got done=%b ab=%b req=%b, want 1 1 0", done, aborted, row_req);
        else passed++;
        @(negedge aclk);
        checks++;
        if (req_count !== r0) $display("FAIL abort_load_no_req: got %0d requests, want 0", req_count - r0);
        else passed++;
    endtask

    task automatic test_start_abort_same;
        bit seen;
        busy_len = 2;
        push_rows(32'h50000, 32'h60000, 32'h0, 32'h0, 1, 32'h7);
        do_start(32'h50000, 32'h60000, 32'h0, 32'h0, 16'd1, 32'h7, 1'b1);
        wait_done(seen);
        checks++;
        if ({seen, aborted} !== 2'b10 || sb_q.size() !== 0)
            $display("FAIL start_abort_same: got done=%b ab=%b left=%0d, want 1 0 0", seen, aborted, sb_q.size());
        else passed++;
        @(negedge aclk);
    endtask

    task automatic test_neg_step;
        bit seen;
        busy_len = 3;
        push_rows(32'h0, 32'h0, 32'hFFFF0000, 32'h0, 2, 32'h8);
        do_start(32'h0, 32'h0, 32'hFFFF0000, 32'h0, 16'd2, 32'h8, 1'b0);
        wait_done(seen);
        checks++;
        if ({seen, aborted} !== 2'b10 || sb_q.size() !== 0)
            $display("FAIL neg_step: got done=%b ab=%b left=%0d, want 1 0 0", seen, aborted, sb_q.size());
        else passed++;
        @(negedge aclk);
    endtask

    task automatic test_reset_mid;
        bit seen;
        busy_len = 10;
        push_rows(32'h0, 32'h20000, 32'h0, 32'h10000, 2, 32'h3);
        do_start(32'h0, 32'h20000, 32'h0, 32'h10000, 16'd2, 32'h3, 1'b0);
        for (int k = 0; k < 100; k++) begin
            if (row_busy) break;
            @(negedge aclk);
        end
        @(negedge aclk);
        areset = 1'b1;
        @(negedge aclk);
        checks++;
        if ({busy, row_req, done, xcur, row_idx} !== 51'd0)
            $display("FAIL reset_mid: got busy=%b req=%b done=%b x=%h idx=%0d, want all 0", busy, row_req, done, xcur, row_idx);
        else passed++;
        areset = 1'b0;
        sb_q.delete();
        @(negedge aclk);
        busy_len = 3;
        push_rows(32'h30000, 32'h10000, 32'h0, 32'h0, 1, 32'h9);
        do_start(32'h30000, 32'h10000, 32'h0, 32'h0, 16'd1, 32'h9, 1'b0);
        wait_done(seen);
        checks++;
        if ({seen, aborted} !== 2'b10 || sb_q.size() !== 0)
            $display("FAIL after_reset_run: got done=%b ab=%b left=%0d, want 1 0 0", seen, aborted, sb_q.size());
        else passed++;
        @(negedge aclk);
    endtask

`ifdef DRAW_SCHED_CLIP_EN
    task automatic test_clip;
        bit seen;
        int r0 = req_count;
        busy_len = 3;
        push_rows(32'h0, 32'h0, 32'h0, 32'h10000, 2, 32'h6);
        sb_q[0].idx = 16'd1;
        sb_q[1].idx = 16'd2;
        do_start(32'h0, 32'hFFFF0000, 32'h0, 32'h10000, 16'd3, 32'h6, 1'b0);
        wait_done(seen);
        checks++;
        if ({seen, aborted} !== 2'b10 || (req_count - r0 !== 2) || sb_q.size() !== 0)
            $display("FAIL clip: got done=%b ab=%b reqs=%0d left=%0d, want 1 0 2 0", seen, aborted, req_count - r0, sb_q.size());
        else passed++;
        @(negedge aclk);
    endtask
`endif

    initial begin
        areset = 1'b1; start = 1'b0; abort = 1'b0;
        xpos_in = 32'h0; ypos_in = 32'h0; vdx_in = 32'h0; vdy_in = 32'h0;
        nrows_in = 16'd0; cnt_in = 32'h0;
        @(negedge aclk);
        test_reset;
        test_basic;
        test_zero_rows;
        test_abort_wait;
        test_abort_load;
        test_start_abort_same;
        test_neg_step;
        test_reset_mid;
`ifdef DRAW_SCHED_CLIP_EN
        test_clip;
`endif
        repeat (2) @(negedge aclk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
